// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus: redirect input, instruction-memory req/gnt/rvalid channel and decode handshake.
// With FETCH_PERF_EN defined the bundle also carries the fetch/drop performance counters.
interface ifetch_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          dec_valid;
    logic          dec_ready;
    logic [31:0]   dec_instr;
    logic [31:0]   dec_pc;
    logic [CW-1:0] fifo_count;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_drop_cnt;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fifo_count,
               perf_fetch_cnt, perf_drop_cnt
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fifo_count,
               perf_fetch_cnt, perf_drop_cnt
    );
`else
    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fifo_count
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fifo_count
    );
`endif
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one outstanding imem request, {pc, instr} FIFO towards decode, redirect flush.
// Optional FETCH_PERF_EN adds push and dropped-response counters.
//
// state  | meaning
// S_REQ  | request next fetch_pc when the FIFO has a free slot
// S_WAIT | one request outstanding, waiting for its response
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    ifetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          discard_q, discard_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic fire, rsp, push, pop;
    logic unused_pc_lsb;

    assign unused_pc_lsb = ^bus.redirect_pc[1:0];

    assign bus.imem_req   = ~reset & (state_q == S_REQ) & (count_q < FULL);
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.dec_valid  = ~reset & (count_q != '0);
    assign bus.dec_pc     = pc_mem_q[rd_ptr_q];
    assign bus.dec_instr  = instr_mem_q[rd_ptr_q];
    assign bus.fifo_count = count_q;

    assign fire = bus.imem_req & bus.imem_gnt;
    assign rsp  = (state_q == S_WAIT) & bus.imem_rvalid;
    assign push = rsp & ~discard_q & ~bus.redirect_valid;
    assign pop  = bus.dec_valid & bus.dec_ready & ~bus.redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        if (state_q == S_REQ) begin
            if (fire) begin
                state_d    = S_WAIT;
                req_pc_d   = fetch_pc_q;
                discard_d  = bus.redirect_valid;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end else if (bus.imem_rvalid) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
        end else if (bus.redirect_valid) begin
            discard_d = 1'b1;
        end
        // redirect target overrides the sequential increment, even on a grant
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (bus.redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            discard_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_drop_q;

    assign bus.perf_fetch_cnt = perf_fetch_q;
    assign bus.perf_drop_cnt  = perf_drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(push);
            perf_drop_q  <= perf_drop_q + 32'(rsp & (discard_q | bus.redirect_valid));
        end
    end
`endif
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction fetch stage sitting directly upstream of the decode stage (ID) in the CPU core. It replaces the bare pc_reg-to-ID path. It generates sequential fetch addresses and talks to a variable-latency instruction memory over a request/grant/response interface. Fetched {pc, instr} pairs are buffered in a small FIFO and presented to decode with a valid/ready handshake. A branch/jump redirect flushes the queue and discards any in-flight response.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced to 0)
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (word aligned)
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response valid; responses return in order
imem_rdata  in  32  instruction word
dec_valid  out  1  FIFO head valid
dec_ready  in  1  decode consumes head this cycle
dec_instr  out  32  head instruction
dec_pc  out  32  head instruction address
fifo_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset values (reset sampled at clk edge): fetch_pc=RESET_PC, state=S_REQ, discard=0, FIFO empty, fifo_count=0. Outputs: dec_valid=0, imem_req=0 while reset is high. Reset overrides redirect and all handshakes.
- At most one request outstanding. FSM has two states:
  - S_REQ: imem_req = (fifo_count < DEPTH), imem_addr = fetch_pc. On imem_req & imem_gnt: latch req_pc = fetch_pc, fetch_pc += 4 (wraps mod 2^32), go to S_WAIT. imem_rvalid is ignored in S_REQ (stale responses dropped).
  - S_WAIT: imem_req = 0. On imem_rvalid: if discard=0, push {req_pc, imem_rdata}. Clear discard and go to S_REQ.
- Throughput: at most one instruction per 2 cycles, plus memory latency. An entry pushed at edge N is visible on dec_valid/dec_pc/dec_instr after edge N (1-cycle latency from rvalid).
- Credit rule: a request issues only when fifo_count < DEPTH, so a push never hits a full FIFO. Push and pop in the same cycle leave fifo_count unchanged.
- Decode handshake:
  - dec_valid = FIFO not empty; dec_instr/dec_pc come from the head.
  - Pop on dec_valid & dec_ready & !redirect_valid.
  - Head outputs are stable while dec_valid=1 and dec_ready=0.
- Redirect (redirect_valid=1), all effects at the same edge:
  - FIFO flushed (fifo_count=0). A concurrent pop and a concurrent push are both suppressed.
  - fetch_pc = {redirect_pc[31:2],2'b00}; the +4 increment is suppressed even if a grant occurs that cycle.
  - S_REQ with imem_gnt=1: go to S_WAIT with discard=1.
  - S_REQ with imem_gnt=0: stay in S_REQ.
  - S_WAIT with imem_rvalid=0: discard=1, stay in S_WAIT.
  - S_WAIT with imem_rvalid=1: response dropped, go to S_REQ.
- Back-to-back redirects: the last one wins.
- FIFO pointers wrap mod DEPTH.

Optional Feature:
FETCH_PERF_EN. When defined, adds two outputs:
- perf_fetch_cnt (32): count of FIFO pushes.
- perf_drop_cnt (32): count of discarded responses (rvalid in S_WAIT with discard=1 or concurrent redirect).
Both reset to 0 and wrap at 2^32. When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then memory grants immediately with rvalid 1 cycle later; dec_ready=1, rdata = addr^32'hA5A5_0000 -> imem_addr sequence 0x0,0x4,0x8; dec_pc/dec_instr pairs match in order; dec_valid=0 during reset.
- dec_ready=0 with a fast memory -> after 4 pushes fifo_count=4 and imem_req stays 0; one pop -> fifo_count=3 and imem_req=1 the next cycle at addr 0x10.
- Redirect to 0x103 while in S_WAIT; memory later returns 0xDEADBEEF -> word dropped, dec_valid stays 0, next imem_addr=0x100, first dec_pc=0x100.
- Redirect to 0x200 in the same cycle as the grant for 0x8 -> 0x8 response discarded, next request address 0x200 (not 0x204), fifo_count=0.
- Redirect in the same cycle as rvalid and dec_ready with 2 entries queued -> fifo_count=0, no push; with FETCH_PERF_EN, perf_drop_cnt increments by 1.
- Reset asserted with a request outstanding; stale rvalid arrives 1 cycle after reset drops -> ignored, first dec_pc=RESET_PC with the instruction from the new request.
